// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO multiply-divide controller: 32-cycle radix-2 MULTU (shift-add) and DIVU (restoring),
// plus MTHI/MTLO writes. A single shared 2*WIDTH accumulator holds the product or {rem, quo}.
module hilo_muldiv_ctrl #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             op_valid,
  input  logic [2:0]       op_code,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             flush,
  output logic             op_ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

  localparam logic [5:0] LastIter = 6'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [5:0]         cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic               ready_q, ready_d, busy_q, busy_d, done_q, done_d;

  logic               accept;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_diff;
  logic               qbit;
  logic [2*WIDTH-1:0] mul_step, div_step;

  always_comb begin
    accept   = op_valid & ready_q & ~flush;
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
    mul_step = {mul_sum, acc_q[WIDTH-1:1]};
    // Partial remainder {rem, next dividend bit} against divisor; bit WIDTH set means borrow.
    div_diff = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, b_q};
    // Forcing quotient bits to 1 on a zero divisor yields all-ones quotient, remainder = dividend.
    qbit     = ~div_diff[WIDTH] | (b_q == '0);
    div_step = {(qbit ? div_diff[WIDTH-1:0] : acc_q[2*WIDTH-2:WIDTH-1]), acc_q[WIDTH-2:0], qbit};

    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    acc_d   = acc_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          case (op_code)
            3'b000: begin
              a_d     = op_a;
              b_d     = op_b;
              cnt_d   = '0;
              acc_d   = {{WIDTH{1'b0}}, op_b};
              state_d = StMul;
            end
            3'b001: begin
              a_d     = op_a;
              b_d     = op_b;
              cnt_d   = '0;
              acc_d   = {{WIDTH{1'b0}}, op_a};
              state_d = StDiv;
            end
            3'b010:  hi_d = op_a;
            3'b011:  lo_d = op_a;
            default: ;
          endcase
        end
      end
      StMul: begin
        if (flush) begin
          state_d = StIdle;
        end else begin
          acc_d = mul_step;
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == LastIter) begin
            hi_d    = mul_step[2*WIDTH-1:WIDTH];
            lo_d    = mul_step[WIDTH-1:0];
            state_d = StDone;
          end
        end
      end
      StDiv: begin
        if (flush) begin
          state_d = StIdle;
        end else begin
          acc_d = div_step;
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == LastIter) begin
            hi_d    = div_step[2*WIDTH-1:WIDTH];
            lo_d    = div_step[WIDTH-1:0];
            state_d = StDone;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    ready_d = (state_d == StIdle);
    busy_d  = (state_d != StIdle);
    done_d  = (state_d == StDone);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      acc_q   <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      acc_q   <= acc_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign op_ready = ready_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Directed bench for hilo_muldiv_ctrl: arithmetic results, latency, MTHI/MTLO, flush and reset.
module tb_hilo_muldiv_ctrl;

  logic        clk;
  logic        rst_n;
  logic        op_valid;
  logic [2:0]  op_code;
  logic [31:0] op_a, op_b;
  logic        flush;
  logic        op_ready, busy, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;
  int lat;

  hilo_muldiv_ctrl #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .op_valid (op_valid),
    .op_code  (op_code),
    .op_a     (op_a),
    .op_b     (op_b),
    .flush    (flush),
    .op_ready (op_ready),
    .busy     (busy),
    .done     (done),
    .hi       (hi),
    .lo       (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op, then hold (h_code, h_a, h_b) on the inputs with op_valid high for hold_n
  // cycles; returns the number of edges from the accept edge until done is seen (0 = timeout).
  task automatic issue(input logic [2:0] code, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] h_code, input logic [31:0] h_a,
                       input logic [31:0] h_b, input int hold_n, output int latency);
    op_valid = 1'b1;
    op_code  = code;
    op_a     = a;
    op_b     = b;
    tick();
    op_code  = h_code;
    op_a     = h_a;
    op_b     = h_b;
    op_valid = (hold_n > 0);
    latency  = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (i == hold_n) op_valid = 1'b0;
      if (done) begin
        latency = i;
        break;
      end
    end
    op_valid = 1'b0;
  endtask

  initial begin
    rst_n    = 1'b1;
    op_valid = 1'b0;
    op_code  = 3'b000;
    op_a     = '0;
    op_b     = '0;
    flush    = 1'b0;

    // Asynchronous reset before any clock edge
    #2 rst_n = 1'b0;
    #1;
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_ready", op_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    tick();
    tick();
    #2 rst_n = 1'b1;

    // MULTU max x max, with operand inputs scrambled after accept
    issue(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b000, 32'h1234_5678, 32'h0, 0, lat);
    check("mul_lat", lat, 32);
    check("mul_hi", hi, 32'hFFFF_FFFE);
    check("mul_lo", lo, 32'h0000_0001);
    check("mul_ready_at_done", op_ready, 0);
    tick();
    check("mul_done_pulse", done, 0);
    check("mul_ready_after", op_ready, 1);

    issue(3'b001, 32'd100, 32'd7, 3'b000, 32'd9, 32'd9, 0, lat);
    check("div1_lat", lat, 32);
    check("div1_lo", lo, 32'd14);
    check("div1_hi", hi, 32'd2);
    tick();

    issue(3'b001, 32'h8000_0000, 32'd3, 3'b000, 32'd0, 32'd0, 0, lat);
    check("div2_lo", lo, 32'h2AAA_AAAA);
    check("div2_hi", hi, 32'd2);
    tick();

    issue(3'b001, 32'd5, 32'd0, 3'b000, 32'd0, 32'd0, 0, lat);
    check("div0_lat", lat, 32);
    check("div0_lo", lo, 32'hFFFF_FFFF);
    check("div0_hi", hi, 32'd5);
    tick();

    // MTHI then MTLO back to back
    op_valid = 1'b1;
    op_code  = 3'b010;
    op_a     = 32'h1234_5678;
    tick();
    check("mthi_hi", hi, 32'h1234_5678);
    check("mthi_done", done, 0);
    check("mthi_ready", op_ready, 1);
    op_code = 3'b011;
    op_a    = 32'h9ABC_DEF0;
    tick();
    check("mtlo_lo", lo, 32'h9ABC_DEF0);
    check("mtlo_hi", hi, 32'h1234_5678);
    check("mtlo_done", done, 0);
    op_valid = 1'b0;

    // MULTU 3x4 held for 5 cycles while a DIVU runs must be ignored
    issue(3'b001, 32'd100, 32'd7, 3'b000, 32'd3, 32'd4, 5, lat);
    check("busy_ign_lat", lat, 32);
    check("busy_ign_lo", lo, 32'd14);
    check("busy_ign_hi", hi, 32'd2);
    tick();
    check("busy_ign_idle", busy, 0);

    // Flush a DIVU at iteration 10
    op_valid = 1'b1;
    op_code  = 3'b010;
    op_a     = 32'hA;
    tick();
    op_code = 3'b011;
    op_a    = 32'hB;
    tick();
    op_code = 3'b001;
    op_a    = 32'd1000;
    op_b    = 32'd3;
    tick();
    op_valid = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_ready", op_ready, 1);
    check("flush_busy", busy, 0);
    check("flush_hi", hi, 32'hA);
    check("flush_lo", lo, 32'hB);
    check("flush_done", done, 0);
    for (int i = 0; i < 30; i++) tick();
    check("flush_stays_hi", hi, 32'hA);

    // Flush in DONE keeps the committed result
    issue(3'b000, 32'd3, 32'd5, 3'b000, 32'd0, 32'd0, 0, lat);
    check("fdone_seen", lat, 32);
    flush = 1'b1;
    tick();
    check("fdone_lo", lo, 32'd15);
    check("fdone_hi", hi, 32'd0);
    check("fdone_done", done, 0);
    check("fdone_ready", op_ready, 1);

    // Flush beats op_valid in IDLE, including MTHI
    op_valid = 1'b1;
    op_code  = 3'b010;
    op_a     = 32'hDEAD_BEEF;
    tick();
    check("fprio_mthi", hi, 32'd0);
    op_code = 3'b000;
    tick();
    check("fprio_mul", busy, 0);
    flush = 1'b0;

    // Reserved op_code ignored
    op_code = 3'b110;
    op_a    = 32'h5555_5555;
    tick();
    check("resv_busy", busy, 0);
    check("resv_hi", hi, 32'd0);
    check("resv_lo", lo, 32'd15);
    op_valid = 1'b0;

    // Reset between edges in the middle of a MULTU
    op_valid = 1'b1;
    op_code  = 3'b000;
    op_a     = 32'd7;
    op_b     = 32'd9;
    tick();
    op_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    #2 rst_n = 1'b0;
    #1;
    check("mrst_busy", busy, 0);
    check("mrst_lo", lo, 0);
    check("mrst_hi", hi, 0);
    check("mrst_ready", op_ready, 1);
    tick();
    #2 rst_n = 1'b1;
    issue(3'b000, 32'd3, 32'd4, 3'b000, 32'd0, 32'd0, 0, lat);
    check("post_rst_lat", lat, 32);
    check("post_rst_lo", lo, 32'd12);
    check("post_rst_hi", hi, 32'd0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
